// File: rtl/reu_bus_ctl_if.sv
// Bus-arbitration signal bundle between the C64 bus timing logic and the
// REU bus controller. The controller sits on the slave side.
interface reu_bus_ctl_if;
  logic phi2_start;
  logic cpu_rw;
  logic vic_steal;
  logic dma_req;
  logic cpu_rdy;
  logic dma_active;
  logic dma_cycle;
  logic overrun;

  modport master (
    output phi2_start, cpu_rw, vic_steal, dma_req,
    input  cpu_rdy, dma_active, dma_cycle, overrun
  );

  modport slave (
    input  phi2_start, cpu_rw, vic_steal, dma_req,
    output cpu_rdy, dma_active, dma_cycle, overrun
  );
endinterface

// File: rtl/reu_bus_ctl.sv
// REU bus controller: halts the 6510 through RDY, waits for the CPU to reach
// a read cycle (or gives up after HALT_MAX write cycles), then takes over the
// CPU phi2 slot and opens one DMA_LEN-clk access window per free phi2
// half-cycle. All outputs are registered.
module reu_bus_ctl #(
  parameter int DMA_LEN  = 16,
  parameter int HALT_MAX = 3
) (
  input  logic         clk,
  input  logic         reset,
  reu_bus_ctl_if.slave bus
);

  localparam int              HCW       = (HALT_MAX < 1) ? 1 : $clog2(HALT_MAX + 1);
  localparam logic [HCW-1:0]  HALT_LAST = HCW'(HALT_MAX);
  localparam logic [4:0]      WIN_LAST  = 5'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HALT  = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic           cpu_rdy_q, cpu_rdy_nxt;
  logic           dma_active_q, dma_active_nxt;
  logic           dma_cycle_q, dma_cycle_nxt;
  logic           overrun_q, overrun_nxt;
  logic [HCW-1:0] halt_cnt, halt_cnt_nxt;
  logic [4:0]     win_cnt, win_cnt_nxt;

  // A window in its final clk counts as expired: a phi2 strobe landing on
  // that clk may open the next window back-to-back instead of overrunning.
  logic win_last;
  logic win_busy;
  assign win_last = dma_cycle_q && (win_cnt == WIN_LAST);
  assign win_busy = dma_cycle_q && !win_last;

  // Next-state and registered-output decode; window timing runs independently
  // of dma_req so an open window always completes.
  always_comb begin
    state_nxt      = state;
    cpu_rdy_nxt    = cpu_rdy_q;
    dma_active_nxt = dma_active_q;
    dma_cycle_nxt  = dma_cycle_q;
    overrun_nxt    = 1'b0;
    halt_cnt_nxt   = halt_cnt;
    win_cnt_nxt    = win_cnt;

    if (dma_cycle_q) begin
      if (win_last) begin
        dma_cycle_nxt = 1'b0;
        win_cnt_nxt   = 5'd0;
      end else begin
        win_cnt_nxt = win_cnt + 5'd1;
      end
    end

    case (state)
      IDLE: begin
        cpu_rdy_nxt    = 1'b1;
        dma_active_nxt = 1'b0;
        if (bus.dma_req) begin
          cpu_rdy_nxt  = 1'b0;
          halt_cnt_nxt = '0;
          state_nxt    = HALT;
        end
      end

      HALT: begin
        if (!bus.dma_req) begin
          cpu_rdy_nxt    = 1'b1;
          dma_active_nxt = 1'b0;
          state_nxt      = IDLE;
        end else if (bus.phi2_start) begin
          // RDY only stops the 6510 on a read cycle; writes run through.
          if (bus.cpu_rw || (halt_cnt == HALT_LAST)) begin
            dma_active_nxt = 1'b1;
            state_nxt      = GRANT;
          end else begin
            halt_cnt_nxt = halt_cnt + 1'b1;
          end
        end
      end

      GRANT: begin
        if (bus.phi2_start) begin
          if (win_busy) begin
            overrun_nxt = 1'b1;
          end else if (bus.dma_req && !bus.vic_steal) begin
            dma_cycle_nxt = 1'b1;
            win_cnt_nxt   = 5'd0;
          end
        end
        if (!bus.dma_req && !dma_cycle_q) begin
          dma_active_nxt = 1'b0;
          cpu_rdy_nxt    = 1'b1;
          state_nxt      = IDLE;
        end
      end

      default: begin
        cpu_rdy_nxt    = 1'b1;
        dma_active_nxt = 1'b0;
        dma_cycle_nxt  = 1'b0;
        state_nxt      = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset to the released-bus state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cpu_rdy_q    <= 1'b1;
      dma_active_q <= 1'b0;
      dma_cycle_q  <= 1'b0;
      overrun_q    <= 1'b0;
      halt_cnt     <= '0;
      win_cnt      <= 5'd0;
    end else begin
      state        <= state_nxt;
      cpu_rdy_q    <= cpu_rdy_nxt;
      dma_active_q <= dma_active_nxt;
      dma_cycle_q  <= dma_cycle_nxt;
      overrun_q    <= overrun_nxt;
      halt_cnt     <= halt_cnt_nxt;
      win_cnt      <= win_cnt_nxt;
    end
  end

  assign bus.cpu_rdy    = cpu_rdy_q;
  assign bus.dma_active = dma_active_q;
  assign bus.dma_cycle  = dma_cycle_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_reu_bus_ctl.sv
// Testbench for reu_bus_ctl: scenario tasks drive the bus and check outputs
// inline; expected dma_cycle window lengths are queued as strobes are driven
// and compared by a monitor when each window closes.
module tb_reu_bus_ctl;
  localparam int DMA_LEN  = 16;
  localparam int HALT_MAX = 3;

  logic clk;
  logic reset;
  reu_bus_ctl_if bus();

  reu_bus_ctl #(.DMA_LEN(DMA_LEN), .HALT_MAX(HALT_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int win_q[$];
  int run_len = 0;
  int exp_len = 0;
  int ovr_total = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor on the falling edge: bus invariants, overrun tally, window lengths.
  always @(negedge clk) begin
    if (bus.overrun === 1'b1) ovr_total++;
    checks++;
    if ((bus.cpu_rdy === 1'b1 && bus.dma_cycle === 1'b1) ||
        (bus.dma_cycle === 1'b1 && bus.dma_active !== 1'b1)) begin
      errors++;
      $display("FAIL bus_invariant cpu_rdy=%b dma_active=%b dma_cycle=%b required dma_cycle only with cpu_rdy=0 and dma_active=1",
               bus.cpu_rdy, bus.dma_active, bus.dma_cycle);
    end
    if (bus.dma_cycle === 1'b1) begin
      run_len++;
    end else if (run_len > 0) begin
      checks++;
      if (win_q.size() == 0) begin
        errors++;
        $display("FAIL window_unexpected length %0d required no window", run_len);
      end else begin
        exp_len = win_q.pop_front();
        if (run_len != exp_len) begin
          errors++;
          $display("FAIL window_length got %0d expected %0d", run_len, exp_len);
        end
      end
      run_len = 0;
    end
  end

  // Global time limit so the bench always terminates.
  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic rw, input logic vic);
    bus.phi2_start = 1'b1;
    bus.cpu_rw     = rw;
    bus.vic_steal  = vic;
    step(1);
    bus.phi2_start = 1'b0;
    bus.vic_steal  = 1'b0;
  endtask

  // Reach GRANT through a read cycle and finish out that phase (32 clks).
  task automatic enter_grant();
    bus.dma_req = 1'b1;
    step(1);
    strobe(1'b1, 1'b0);
    step(31);
  endtask

  task automatic release_bus();
    bus.dma_req = 1'b0;
    step(2);
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (win_q.size() != 0) begin
      errors++;
      $display("FAIL %s_windows_missing got %0d pending expected 0", name, win_q.size());
    end
    win_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.phi2_start = 1'b0; bus.cpu_rw = 1'b1; bus.vic_steal = 1'b0; bus.dma_req = 1'b0;
    step(2);
    checks++; if (bus.cpu_rdy !== 1'b1)    begin errors++; $display("FAIL reset_cpu_rdy got %b expected 1", bus.cpu_rdy); end
    checks++; if (bus.dma_active !== 1'b0) begin errors++; $display("FAIL reset_dma_active got %b expected 0", bus.dma_active); end
    checks++; if (bus.dma_cycle !== 1'b0)  begin errors++; $display("FAIL reset_dma_cycle got %b expected 0", bus.dma_cycle); end
    checks++; if (bus.overrun !== 1'b0)    begin errors++; $display("FAIL reset_overrun got %b expected 0", bus.overrun); end
    reset = 1'b0;
    step(2);
  endtask

  task automatic test_basic();
    bus.dma_req = 1'b1;
    step(1);
    checks++; if (bus.cpu_rdy !== 1'b0)    begin errors++; $display("FAIL basic_rdy_drop got %b expected 0", bus.cpu_rdy); end
    checks++; if (bus.dma_active !== 1'b0) begin errors++; $display("FAIL basic_halt_active got %b expected 0", bus.dma_active); end
    strobe(1'b1, 1'b0);
    checks++; if (bus.dma_active !== 1'b1) begin errors++; $display("FAIL basic_grant_active got %b expected 1", bus.dma_active); end
    checks++; if (bus.dma_cycle !== 1'b0)  begin errors++; $display("FAIL basic_grant_no_win got %b expected 0", bus.dma_cycle); end
    step(31);
    for (int p = 0; p < 3; p++) begin
      win_q.push_back(DMA_LEN);
      strobe(1'b1, 1'b0);
      checks++; if (bus.dma_cycle !== 1'b1) begin errors++; $display("FAIL basic_win_open phase %0d got %b expected 1", p, bus.dma_cycle); end
      step(31);
      checks++; if (bus.cpu_rdy !== 1'b0 || bus.dma_cycle !== 1'b0) begin
        errors++; $display("FAIL basic_phase_end phase %0d cpu_rdy=%b dma_cycle=%b expected 0 0", p, bus.cpu_rdy, bus.dma_cycle);
      end
    end
    bus.dma_req = 1'b0;
    step(1);
    checks++; if (bus.cpu_rdy !== 1'b1 || bus.dma_active !== 1'b0) begin
      errors++; $display("FAIL basic_release cpu_rdy=%b dma_active=%b expected 1 0", bus.cpu_rdy, bus.dma_active);
    end
    step(1);
    check_queue_empty("basic");
  endtask

  task automatic test_halt_timeout();
    logic exp_act;
    logic exp_win;
    bus.dma_req = 1'b1;
    bus.cpu_rw  = 1'b0;
    step(1);
    for (int k = 1; k <= 5; k++) begin
      exp_act = (k >= HALT_MAX + 1);
      exp_win = (k == HALT_MAX + 2);
      if (exp_win) win_q.push_back(DMA_LEN);
      strobe(1'b0, 1'b0);
      checks++; if (bus.dma_active !== exp_act) begin errors++; $display("FAIL halt_grant strobe %0d got %b expected %b", k, bus.dma_active, exp_act); end
      checks++; if (bus.dma_cycle !== exp_win)  begin errors++; $display("FAIL halt_window strobe %0d got %b expected %b", k, bus.dma_cycle, exp_win); end
      step(7);
    end
    step(20);
    bus.dma_req = 1'b0;
    step(1);
    checks++; if (bus.cpu_rdy !== 1'b1) begin errors++; $display("FAIL halt_release got %b expected 1", bus.cpu_rdy); end
    bus.cpu_rw = 1'b1;
    step(1);
    check_queue_empty("halt");
  endtask

  task automatic test_vic_steal();
    logic vic;
    enter_grant();
    for (int p = 1; p <= 4; p++) begin
      vic = (p == 2);
      if (!vic) win_q.push_back(DMA_LEN);
      strobe(1'b1, vic);
      checks++; if (bus.dma_cycle !== !vic)  begin errors++; $display("FAIL vic_window phase %0d got %b expected %b", p, bus.dma_cycle, !vic); end
      checks++; if (bus.dma_active !== 1'b1) begin errors++; $display("FAIL vic_active phase %0d got %b expected 1", p, bus.dma_active); end
      step(31);
      checks++; if (bus.cpu_rdy !== 1'b0)    begin errors++; $display("FAIL vic_rdy_low phase %0d got %b expected 0", p, bus.cpu_rdy); end
    end
    release_bus();
    check_queue_empty("vic");
  endtask

  task automatic test_req_drop();
    enter_grant();
    win_q.push_back(DMA_LEN);
    strobe(1'b1, 1'b0);
    step(4);
    bus.dma_req = 1'b0;
    step(10);
    checks++; if (bus.dma_cycle !== 1'b1) begin errors++; $display("FAIL drop_win_runs got %b expected 1", bus.dma_cycle); end
    step(1);
    checks++; if (bus.dma_cycle !== 1'b1) begin errors++; $display("FAIL drop_win_last got %b expected 1", bus.dma_cycle); end
    step(1);
    checks++; if (bus.dma_cycle !== 1'b0 || bus.dma_active !== 1'b1 || bus.cpu_rdy !== 1'b0) begin
      errors++; $display("FAIL drop_win_end dma_cycle=%b dma_active=%b cpu_rdy=%b expected 0 1 0", bus.dma_cycle, bus.dma_active, bus.cpu_rdy);
    end
    step(1);
    checks++; if (bus.dma_active !== 1'b0 || bus.cpu_rdy !== 1'b1) begin
      errors++; $display("FAIL drop_release dma_active=%b cpu_rdy=%b expected 0 1", bus.dma_active, bus.cpu_rdy);
    end
    step(1);
    check_queue_empty("drop");
  endtask

  task automatic test_overrun();
    int base;
    logic exp_ovr;
    enter_grant();
    base = ovr_total;
    for (int k = 0; k < 6; k++) begin
      exp_ovr = (k % 2 == 1);
      if (!exp_ovr) win_q.push_back(DMA_LEN);
      strobe(1'b1, 1'b0);
      checks++; if (bus.overrun !== exp_ovr)  begin errors++; $display("FAIL ovr_pulse strobe %0d got %b expected %b", k, bus.overrun, exp_ovr); end
      checks++; if (bus.dma_cycle !== 1'b1)   begin errors++; $display("FAIL ovr_window strobe %0d got %b expected 1", k, bus.dma_cycle); end
      step(1);
      checks++; if (bus.overrun !== 1'b0)     begin errors++; $display("FAIL ovr_one_clk strobe %0d got %b expected 0", k, bus.overrun); end
      step(10);
    end
    step(4);
    checks++; if (ovr_total - base != 3) begin errors++; $display("FAIL ovr_count got %0d expected 3", ovr_total - base); end
    release_bus();
    check_queue_empty("ovr");
  endtask

  task automatic test_back_to_back();
    int base;
    // Strobes exactly DMA_LEN apart: each lands on the expiring clk of the
    // previous window, so the windows chain into one unbroken high period.
    enter_grant();
    base = ovr_total;
    win_q.push_back(3 * DMA_LEN);
    for (int k = 0; k < 3; k++) begin
      strobe(1'b1, 1'b0);
      checks++; if (bus.dma_cycle !== 1'b1) begin errors++; $display("FAIL b2b_window strobe %0d got %b expected 1", k, bus.dma_cycle); end
      checks++; if (bus.overrun !== 1'b0)   begin errors++; $display("FAIL b2b_overrun strobe %0d got %b expected 0", k, bus.overrun); end
      step(DMA_LEN - 1);
    end
    step(2);
    checks++; if (bus.dma_cycle !== 1'b0)  begin errors++; $display("FAIL b2b_end got %b expected 0", bus.dma_cycle); end
    checks++; if (ovr_total != base)       begin errors++; $display("FAIL b2b_ovr_count got %0d expected 0", ovr_total - base); end
    // Release then re-request immediately: must go back through HALT.
    bus.dma_req = 1'b0;
    step(1);
    checks++; if (bus.dma_active !== 1'b0 || bus.cpu_rdy !== 1'b1) begin
      errors++; $display("FAIL b2b_idle dma_active=%b cpu_rdy=%b expected 0 1", bus.dma_active, bus.cpu_rdy);
    end
    bus.dma_req = 1'b1;
    step(1);
    checks++; if (bus.cpu_rdy !== 1'b0 || bus.dma_active !== 1'b0) begin
      errors++; $display("FAIL b2b_rehalt cpu_rdy=%b dma_active=%b expected 0 0", bus.cpu_rdy, bus.dma_active);
    end
    step(3);
    checks++; if (bus.dma_active !== 1'b0) begin errors++; $display("FAIL b2b_no_shortcut got %b expected 0", bus.dma_active); end
    strobe(1'b1, 1'b0);
    checks++; if (bus.dma_active !== 1'b1) begin errors++; $display("FAIL b2b_regrant got %b expected 1", bus.dma_active); end
    release_bus();
    check_queue_empty("b2b");
  endtask

  task automatic test_reset_mid();
    enter_grant();
    win_q.push_back(8);
    strobe(1'b1, 1'b0);
    step(7);
    reset = 1'b1;
    step(1);
    checks++; if (bus.dma_cycle !== 1'b0)  begin errors++; $display("FAIL rstwin_dma_cycle got %b expected 0", bus.dma_cycle); end
    checks++; if (bus.dma_active !== 1'b0) begin errors++; $display("FAIL rstwin_dma_active got %b expected 0", bus.dma_active); end
    checks++; if (bus.cpu_rdy !== 1'b1)    begin errors++; $display("FAIL rstwin_cpu_rdy got %b expected 1", bus.cpu_rdy); end
    checks++; if (bus.overrun !== 1'b0)    begin errors++; $display("FAIL rstwin_overrun got %b expected 0", bus.overrun); end
    reset = 1'b0;
    step(1);
    checks++; if (bus.cpu_rdy !== 1'b0 || bus.dma_active !== 1'b0) begin
      errors++; $display("FAIL rst_first_clk cpu_rdy=%b dma_active=%b expected 0 0", bus.cpu_rdy, bus.dma_active);
    end
    reset = 1'b1;
    step(1);
    checks++; if (bus.cpu_rdy !== 1'b1) begin errors++; $display("FAIL rsthalt_cpu_rdy got %b expected 1", bus.cpu_rdy); end
    reset = 1'b0;
    bus.dma_req = 1'b0;
    step(2);
    checks++; if (bus.cpu_rdy !== 1'b1 || bus.dma_active !== 1'b0) begin
      errors++; $display("FAIL rst_idle cpu_rdy=%b dma_active=%b expected 1 0", bus.cpu_rdy, bus.dma_active);
    end
    check_queue_empty("rst");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_halt_timeout();
    test_vic_steal();
    test_req_drop();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reu_bus_ctl.md
REU_BUS_CTL -- requirements
Module: reu_bus_ctl

Interface
REQ-001 SHALL have parameter DMA_LEN, default 16, meaning clk count per DMA window (dma_cycle high time).
REQ-002 SHALL have parameter HALT_MAX, default 3, meaning max phi2 cycles waited for CPU write-cycle completion after RDY drop.
REQ-003 SHALL have port clk  input  1  system clock; reset reset, synchronous, active-high; clock clk.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port phi2_start  input  1  one-clk strobe marking start of each C64 phi2 (CPU) half-cycle.
REQ-006 SHALL have port cpu_rw  input  1  CPU R/W of current bus cycle, 1=read, sampled on phi2_start.
REQ-007 SHALL have port vic_steal  input  1  VIC owns the coming phi2 half-cycle (badline/sprite DMA).
REQ-008 SHALL have port dma_req  input  1  bus request from REU engine.
REQ-009 SHALL have port cpu_rdy  output  1  CPU RDY, 1=run, 0=halt.
REQ-010 SHALL have port dma_active  output  1  address/data bus mux select, 1=REU owns CPU bus slot.
REQ-011 SHALL have port dma_cycle  output  1  REU access window, high for exactly DMA_LEN clks.
REQ-012 SHALL have port overrun  output  1  one-clk pulse when phi2_start arrives during an open window.

Function
REQ-013 SHALL implement FSM states IDLE, HALT, GRANT; all outputs registered.
REQ-014 IDLE: dma_req=1 SHALL drive cpu_rdy=0 on next clk, clear halt_cnt, enter HALT.
REQ-015 HALT: on phi2_start with cpu_rw=1 or halt_cnt==HALT_MAX SHALL set dma_active=1 and enter GRANT; else halt_cnt+1.
REQ-016 HALT: dma_req=0 SHALL return to IDLE with cpu_rdy=1 next clk, dma_active stays 0.
REQ-017 GRANT: on phi2_start with dma_req=1, vic_steal=0, no open window SHALL raise dma_cycle next clk and hold it exactly DMA_LEN clks.
REQ-018 Window counter SHALL be 5 bits, clear at window open, dma_cycle drops on clk after count reaches DMA_LEN-1.
REQ-019 GRANT: phi2_start with vic_steal=1 SHALL open no window; cpu_rdy stays 0, dma_active stays 1.
REQ-020 Open window SHALL run to completion regardless of dma_req falling or vic_steal changing.
REQ-021 phi2_start during open window SHALL be ignored for window opening, pulse overrun for 1 clk, window unchanged.
REQ-022 GRANT: dma_req=0 with no open window SHALL set dma_active=0, cpu_rdy=1 next clk, enter IDLE.
REQ-023 dma_req re-asserted in IDLE on clk after release SHALL restart full HALT sequence (no shortcut).
REQ-024 Max 1 window per phi2 half-cycle; phi2_start and window end on same clk SHALL close window and open new one only if counter expired that clk (new window starts next clk).
REQ-025 cpu_rdy SHALL never be 1 while dma_cycle=1; dma_cycle SHALL never be 1 while dma_active=0.

Reset
REQ-026 reset SHALL force state IDLE, cpu_rdy=1, dma_active=0, dma_cycle=0, overrun=0, counters 0 on next clk, including mid-window and mid-HALT.
REQ-027 After reset release, block SHALL ignore dma_req for no cycles; dma_req=1 on first clk enters HALT.

Verification
REQ-028 phi2_start every 32 clks, cpu_rw=1, dma_req held 3 phases -> cpu_rdy=0 one clk after req, dma_active=1 after first phi2_start, three 16-clk dma_cycle windows at subsequent phi2_starts.
REQ-029 cpu_rw=0 on 5 consecutive phi2_starts, dma_req=1 -> GRANT entered at 4th phi2_start (halt_cnt=3), not earlier.
REQ-030 vic_steal=1 on 2nd of 4 granted phases -> windows only in phases 1,3,4; cpu_rdy stays 0 throughout.
REQ-031 dma_req drops at clk 5 of a window -> window finishes 16 clks, then dma_active=0, cpu_rdy=1 next clk.
REQ-032 phi2_start period 12 clks (< DMA_LEN) -> overrun pulses once per ignored strobe, each window still exactly 16 clks.
REQ-033 reset at clk 8 of a window -> next clk dma_cycle=0, dma_active=0, cpu_rdy=1, state IDLE.
